mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port 32-bit frame-buffer memory among NUM_REQ drawing engines
//  (fill_rect in slot 1; other command-processor engines in the remaining slots).
//  Grants one request per cycle over the rts/rtr handshake and issues it to memory.
//  Broadcasts read data with a per-requester xfc strobe.
// PARAMETERS
//  NUM_REQ  4  number of requester slots (2..8)
//  RD_LAT   2  memory read latency, in cycles from mem_en to mem_rdata valid (1..4)
//  PRIO0    1  1: slot 0 has strict priority over the round-robin slots; 0: slot 0 is plain round-robin
// PORTS
//  clk         in   1           clock; all logic on rising edge
//  rst         in   1           synchronous reset, active-high
//  req_rts     in   NUM_REQ     per-requester ready-to-send
//  req_rtr     out  NUM_REQ     per-requester ready-to-receive (grant)
//  req_op      in   NUM_REQ     per-requester op: 1 = write, 0 = read
//  req_addr    in   16*NUM_REQ  word address; slot i is bits [16i+15:16i]
//  req_data    in   32*NUM_REQ  write data; slot i is bits [32i+31:32i]
//  req_wben    in   4*NUM_REQ   byte write enables; bit 0 is byte [7:0]
//  mem_rdy     in   1           memory can accept a command this cycle
//  mem_en      out  1           memory command valid
//  mem_we      out  1           1 = write command
//  mem_addr    out  16          command address
//  mem_wdata   out  32          write data
//  mem_wben    out  4           byte enables (forced to 4'h0 on reads)
//  mem_rdata   in   32          read data, valid RD_LAT cycles after a read mem_en
//  bcast_data  out  32          registered copy of mem_rdata, shared by all requesters
//  bcast_xfc   out  NUM_REQ     one-hot: bcast_data belongs to slot i this cycle
// BEHAVIOUR
//  Reset: all outputs 0; rr_ptr = 0; read-tag pipeline cleared.
//   Reads in flight at reset are dropped and produce no xfc.
//  Grant (combinational in the current cycle):
//   - No grant while mem_rdy = 0 or rst = 1.
//   - Otherwise, if PRIO0 = 1 and req_rts[0] = 1, grant slot 0.
//   - Else grant the first slot with rts = 1, searching from rr_ptr upward and wrapping
//     (slot 0 is excluded from this search when PRIO0 = 1).
//   - req_rtr is one-hot or zero and depends only on rts, rr_ptr and mem_rdy.
//  Handshake:
//   - A transfer occurs when rts[i] & rtr[i] are both 1.
//   - A requester holds rts and its payload stable until it sees rtr.
//   - A requester's rts must not depend combinationally on its rtr.
//  Pointer update: on a round-robin grant to slot g, rr_ptr <= g+1, wrapping to the
//   first round-robin slot. A priority grant to slot 0 leaves rr_ptr unchanged.
//  Issue: a transfer registers mem_en=1, mem_we=op, mem_addr, mem_wdata, mem_wben
//   onto the memory outputs in the next cycle. Issue latency is 1 cycle. With no
//   transfer, mem_en=0 and the other memory outputs hold their last values.
//  Read return:
//   - Each read pushes the slot ID into an RD_LAT-deep tag shift register.
//   - When the tag reaches the end: bcast_data <= mem_rdata and bcast_xfc <= onehot(tag),
//     one cycle after rdata is valid. Read request to xfc is RD_LAT+2 cycles.
//   - Writes produce no xfc.
//  Throughput: 1 command per cycle sustained while mem_rdy = 1. Reads and writes
//   may interleave back-to-back; returns stay in issue order.
//  Mid-stream: mem_rdy falling stalls new grants only; reads already in flight still return.
// TESTING
//  1 Reset, rts=0 -> all outputs 0; 20 idle cycles -> mem_en never 1.
//  2 Slot1 write addr 16'h0040, data 32'hDEADBEEF, wben 4'hF -> rtr[1] same cycle;
//    next cycle mem_en=1, mem_we=1, mem_addr=16'h0040, mem_wdata=32'hDEADBEEF.
//  3 Slots 1,2,3 hold rts=1 for 9 cycles (PRIO0=1) -> grant order 1,2,3,1,2,3,1,2,3.
//    Slot0 rts pulsed on cycle 4 -> slot 0 granted that cycle; order then resumes unchanged.
//  4 Slot2 read 16'h0010 then slot1 read 16'h0011 back-to-back, RD_LAT=2,
//    model returns addr+32'h100 -> xfc[2] with data 32'h110, then xfc[1] with
//    data 32'h111 on the next cycle, at RD_LAT+2 after each grant.
//  5 mem_rdy=0 for 5 cycles with rts=4'b1111 -> rtr=0, mem_en=0;
//    mem_rdy rises -> slot 0 granted first.
//  6 rst asserted 1 cycle after a read issue -> no bcast_xfc afterwards;
//    rr_ptr restarts so slot 1 is granted first.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 32-bit frame-buffer memory among NUM_REQ
// drawing engines. One request is granted per cycle over the rts/rtr handshake.
// The granted command is registered onto the memory port, and read data is
// broadcast back with a one-hot per-requester xfc strobe.
//
// Ports
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   req_rts      per-slot ready-to-send
//   req_rtr      per-slot grant, combinational, one-hot or zero
//   req_op       per-slot op (1 = write, 0 = read)
//   req_addr     per-slot 16-bit word address, slot i at [16i+15:16i]
//   req_data     per-slot 32-bit write data, slot i at [32i+31:32i]
//   req_wben     per-slot 4-bit byte enables, slot i at [4i+3:4i]
//   mem_rdy      memory accepts a command this cycle
//   mem_en/we/addr/wdata/wben   registered memory command
//   mem_rdata    read data, valid RD_LAT cycles after a read mem_en
//   bcast_data   registered copy of mem_rdata
//   bcast_xfc    one-hot owner of bcast_data this cycle
module mem_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned RD_LAT  = 2,
   parameter int unsigned PRIO0   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_rts,
   output logic [NUM_REQ-1:0]      req_rtr,
   input  logic [NUM_REQ-1:0]      req_op,
   input  logic [16*NUM_REQ-1:0]   req_addr,
   input  logic [32*NUM_REQ-1:0]   req_data,
   input  logic [4*NUM_REQ-1:0]    req_wben,
   input  logic                    mem_rdy,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [15:0]             mem_addr,
   output logic [31:0]             mem_wdata,
   output logic [3:0]              mem_wben,
   input  logic [31:0]             mem_rdata,
   output logic [31:0]             bcast_data,
   output logic [NUM_REQ-1:0]      bcast_xfc
);

   localparam int unsigned PW       = $clog2(NUM_REQ);
   localparam int unsigned AW       = 16;
   localparam int unsigned DW       = 32;
   localparam int unsigned BW       = 4;
   localparam int unsigned FIRST_RR = (PRIO0 != 0) ? 1 : 0;
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   // round-robin pointer and registered memory command
   logic [PW-1:0]      r_rr_ptr;
   logic               r_mem_en;
   logic               r_mem_we;
   logic [AW-1:0]      r_mem_addr;
   logic [DW-1:0]      r_mem_wdata;
   logic [BW-1:0]      r_mem_wben;

   // read tags: stage 0 runs alongside mem_en, stages 1..RD_LAT track the latency
   logic               r_tag_v  [RD_LAT+1];
   logic [PW-1:0]      r_tag_id [RD_LAT+1];

   logic [DW-1:0]      r_bcast_data;
   logic [NUM_REQ-1:0] r_bcast_xfc;

   logic               w_gnt_vld;
   logic               w_rr_gnt;
   logic [PW-1:0]      w_gnt_idx;
   logic [NUM_REQ-1:0] w_gnt;
   logic [PW-1:0]      w_rr_nxt;
   logic               w_gnt_op;
   logic               w_rd;

   // grant select: optional slot-0 priority, then round-robin from r_rr_ptr
   always_comb begin
      int unsigned   v_j;
      logic [PW-1:0] v_idx;
      w_gnt_vld = 1'b0;
      w_rr_gnt  = 1'b0;
      w_gnt_idx = '0;
      v_j       = 0;
      v_idx     = '0;
      if (!rst && mem_rdy) begin
         if ((PRIO0 != 0) && req_rts[0]) begin
            w_gnt_vld = 1'b1;
         end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
               v_j = 32'(r_rr_ptr) + k;
               if (v_j >= NUM_REQ) begin
                  v_j = v_j - NUM_REQ;
               end
               v_idx = PW'(v_j);
               // slot 0 never wins the round-robin search while it owns priority
               if (!w_gnt_vld && req_rts[v_idx] &&
                   !((PRIO0 != 0) && (v_idx == '0))) begin
                  w_gnt_vld = 1'b1;
                  w_rr_gnt  = 1'b1;
                  w_gnt_idx = v_idx;
               end
            end
         end
      end
   end

   assign w_gnt    = w_gnt_vld ? (ONE_HOT0 << w_gnt_idx) : '0;
   assign req_rtr  = w_gnt;
   assign w_gnt_op = req_op[w_gnt_idx];
   assign w_rd     = w_gnt_vld & ~w_gnt_op;

   // pointer moves past a round-robin winner, wrapping to the first round-robin slot
   assign w_rr_nxt = (w_gnt_idx == PW'(NUM_REQ-1)) ? PW'(FIRST_RR) : (w_gnt_idx + PW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= '0;
      end else if (w_rr_gnt) begin
         r_rr_ptr <= w_rr_nxt;
      end
   end

   // issue register: payload holds its last value when nothing is granted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wben  <= '0;
      end else begin
         r_mem_en <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_mem_we    <= w_gnt_op;
            r_mem_addr  <= req_addr[AW*w_gnt_idx +: AW];
            r_mem_wdata <= req_data[DW*w_gnt_idx +: DW];
            r_mem_wben  <= w_gnt_op ? req_wben[BW*w_gnt_idx +: BW] : '0;
         end
      end
   end

   // tag shift register; reset drops any reads still in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k <= RD_LAT; k++) begin
            r_tag_v[k]  <= 1'b0;
            r_tag_id[k] <= '0;
         end
      end else begin
         r_tag_v[0]  <= w_rd;
         r_tag_id[0] <= w_gnt_idx;
         for (int unsigned k = 1; k <= RD_LAT; k++) begin
            r_tag_v[k]  <= r_tag_v[k-1];
            r_tag_id[k] <= r_tag_id[k-1];
         end
      end
   end

   // read return: capture rdata when the matching tag reaches the last stage
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bcast_data <= '0;
         r_bcast_xfc  <= '0;
      end else begin
         if (r_tag_v[RD_LAT]) begin
            r_bcast_data <= mem_rdata;
            r_bcast_xfc  <= ONE_HOT0 << r_tag_id[RD_LAT];
         end else begin
            r_bcast_xfc  <= '0;
         end
      end
   end

   assign mem_en     = r_mem_en;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign mem_wben   = r_mem_wben;
   assign bcast_data = r_bcast_data;
   assign bcast_xfc  = r_bcast_xfc;

endmodule
